data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data memory (1-cycle registered read, byte-enabled write)
//  between N requesters, e.g. core LSU (master 0) and a DMA/debug master (master 1).
//  Round-robin arbitration per cycle; returns read data to the winning master one
//  cycle after grant. Sits between the masters and data_mem in the top level.
// PARAMETERS
//  N_MASTERS   2        number of requesting masters (2..8)
//  FIXED_PRIO  1'b0     1: master 0 always wins (lower index = higher priority); 0: round-robin
// PORTS
//  clk_i         in   1          clock, all logic on posedge
//  rst_ni        in   1          synchronous reset, active-low
//  m_req_i       in   N          per-master request
//  m_we_i        in   N          per-master write enable
//  m_be_i        in   N x 4      per-master byte enables
//  m_addr_i      in   N x 32     per-master byte address
//  m_wdata_i     in   N x 32     per-master write data
//  m_gnt_o       out  N          one-hot grant; request accepted this cycle
//  m_rvalid_o    out  N          one-hot read-data valid (cycle after read grant)
//  m_rdata_o     out  32         shared read data, qualify with m_rvalid_o
//  mem_req_o     out  1          to data_mem mem_req_i
//  mem_we_o      out  1          to data_mem write_enable_i
//  mem_be_o      out  4          to data_mem byte_enable_i
//  mem_addr_o    out  32         to data_mem addr_i
//  mem_wdata_o   out  32         to data_mem write_data_i
//  mem_rdata_i   in   32         from data_mem read_data_o
//  mem_ready_i   in   1          from data_mem ready_o
// BEHAVIOUR
//  - Grant is combinational within the cycle: m_gnt_o[k]=1 iff m_req_i[k] wins and mem_ready_i=1.
//    At most one grant per cycle; no grant when mem_ready_i=0 or no requests.
//  - Downstream mux: mem_req_o=|m_gnt_o; mem_we/be/addr/wdata from granted master; all 0 when idle.
//  - Round-robin: prio_ptr register (clog2 N bits); search starts at prio_ptr, wraps N-1 -> 0.
//    On a grant to k, prio_ptr <= (k+1) mod N. No grant: prio_ptr holds. FIXED_PRIO=1 ignores prio_ptr.
//  - Response tracking: on a granted read (we=0), register rd_pend<=1, rd_id<=k; else rd_pend<=0.
//    Next cycle m_rvalid_o = rd_pend ? onehot(rd_id) : 0. m_rdata_o = rd_pend ? mem_rdata_i : 0.
//    Writes produce no m_rvalid_o. Back-to-back reads: one grant + one rvalid per cycle, pipelined.
//  - Masters hold req/we/be/addr/wdata stable until gnt seen; arbiter does not buffer requests.
//  - Simultaneous equal requests: winner per pointer; same master re-requesting is not starved
//    by others only within N cycles (bounded wait <= N-1 grants to others).
//  - Reset (rst_ni=0 on posedge): prio_ptr<=0, rd_pend<=0, rd_id<=0; outputs during and after
//    reset: m_rvalid_o=0, m_rdata_o=0; grants still combinational but ignored by masters in reset.
//    A read granted the cycle reset asserts yields no rvalid.
// STRUCTURE
//  - memory_pkg: add N_MEM_MASTERS=2 and typedef mem_req_t {we, be[3:0], addr[31:0], wdata[31:0]}.
//  - Sub-module rr_arbiter (req[N], ptr -> one-hot gnt); reused by future peripheral-bus arbiter.
//  - Top: rr_arbiter + one-hot mux + prio_ptr / rd_pend / rd_id registers.
// TESTING (bench instantiates data_mem behind the arbiter, N=2)
//  1 Reset: rst_ni=0 3 cycles, then m_req=2'b00 -> m_gnt=0, m_rvalid=0, mem_req_o=0, prio_ptr=0.
//  2 M0 writes 0xDEADBEEF be=4'hF @0x10, next cycle M0 reads 0x10 -> gnt same cycle, m_rvalid_o=2'b01
//    one cycle later with m_rdata_o=0xDEADBEEF; M1 never sees rvalid.
//  3 Both read continuously (M0 @0x10, M1 @0x14) -> grants alternate 01,10,01,10; rvalid follows
//    one cycle behind with matching data; no two grants in one cycle.
//  4 Partial write M1 be=4'b0010 data 0x0000AB00 over 0xDEADBEEF, read back -> 0xDEADABEF.
//  5 Force mem_ready_i=0 two cycles with both requesting -> no gnt, ptr holds; on release winner per ptr.
//  6 Assert rst_ni=0 in the cycle a read is granted -> no m_rvalid_o next cycle, ptr back to 0.
//    FIXED_PRIO=1 variant: both requesting for 5 cycles -> M0 granted all 5.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared types and constants for the data-memory subsystem.
//   N_MEM_MASTERS : default number of masters sharing data_mem (LSU + DMA/debug)
//   mem_req_t     : one master's request fields as seen by data_mem
//   ptr_width()   : width of a master index / priority pointer for n masters
// ---------------------------------------------------------------------------
package data_mem_arbiter_pkg;

    localparam int N_MEM_MASTERS = 2;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // A single master still needs a 1-bit pointer so port widths never collapse to zero.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Starting at index ptr and wrapping
// from N-1 back to 0, the first asserted request wins. Tying ptr to zero turns
// it into a fixed-priority arbiter (lower index wins).
// Ports:
//   req  in  N      request vector
//   ptr  in  PTR_W  index where the search starts
//   gnt  out N      one-hot grant, all zero when no request
// ---------------------------------------------------------------------------
module rr_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;
    int               pos;

    // Walk the masters in priority order starting at ptr; the first requester
    // found claims the grant and all later candidates are masked off.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = PTR_W'(pos);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port data memory between N_MASTERS requesters. One grant
// per cycle (round-robin or fixed priority), request fields muxed to data_mem,
// and read data routed back to the winning master one cycle after its grant.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   m_req_i/we/be/addr/wdata  per-master request bundle (held until granted)
//   m_gnt_o                one-hot grant, combinational this cycle
//   m_rvalid_o, m_rdata_o  one-hot read-data valid and shared read data
//   mem_*_o                request towards data_mem (all zero when idle)
//   mem_rdata_i, mem_ready_i  data_mem read data and ready
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int N_MASTERS  = N_MEM_MASTERS,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_MASTERS-1:0]        m_req_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS-1:0][3:0]   m_be_i,
    input  logic [N_MASTERS-1:0][31:0]  m_addr_i,
    input  logic [N_MASTERS-1:0][31:0]  m_wdata_i,
    output logic [N_MASTERS-1:0]        m_gnt_o,
    output logic [N_MASTERS-1:0]        m_rvalid_o,
    output logic [31:0]                 m_rdata_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [3:0]                  mem_be_o,
    output logic [31:0]                 mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    input  logic [31:0]                 mem_rdata_i,
    input  logic                        mem_ready_i
);

    localparam int PTR_W = ptr_width(N_MASTERS);

    logic [PTR_W-1:0]     prio_ptr;
    logic [PTR_W-1:0]     arb_ptr;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [N_MASTERS-1:0] arb_req;
    logic [N_MASTERS-1:0] gnt;
    logic                 rd_pend;
    logic [PTR_W-1:0]     rd_id;
    logic                 rd_grant;
    logic                 resp_ok;
    mem_req_t             sel;

    // A busy memory accepts nothing, so hide all requests from the arbiter.
    assign arb_req = mem_ready_i ? m_req_i : '0;
    assign arb_ptr = FIXED_PRIO ? '0 : prio_ptr;

    rr_arbiter #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req (arb_req),
        .ptr (arb_ptr),
        .gnt (gnt)
    );

    assign m_gnt_o = gnt;

    // AND-OR mux of the granted master's fields; the grant is one-hot so at
    // most one term contributes and an idle cycle drives all zeros.
    always_comb begin
        sel     = '0;
        gnt_idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            sel.we    = sel.we    | (gnt[k] & m_we_i[k]);
            sel.be    = sel.be    | ({4{gnt[k]}}  & m_be_i[k]);
            sel.addr  = sel.addr  | ({32{gnt[k]}} & m_addr_i[k]);
            sel.wdata = sel.wdata | ({32{gnt[k]}} & m_wdata_i[k]);
            if (gnt[k]) begin
                gnt_idx = PTR_W'(k);
            end
        end
    end

    assign mem_req_o   = |gnt;
    assign mem_we_o    = sel.we;
    assign mem_be_o    = sel.be;
    assign mem_addr_o  = sel.addr;
    assign mem_wdata_o = sel.wdata;

    assign rd_grant = mem_req_o && !mem_we_o;
    assign next_ptr = (gnt_idx == PTR_W'(N_MASTERS - 1)) ? '0 : gnt_idx + PTR_W'(1);

    // Pointer moves just past the winner so it becomes lowest priority next
    // time; rd_pend/rd_id remember which master owns next cycle's read data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_ptr <= '0;
            rd_pend  <= 1'b0;
            rd_id    <= '0;
        end else begin
            if (mem_req_o) begin
                prio_ptr <= next_ptr;
            end
            rd_pend <= rd_grant;
            if (rd_grant) begin
                rd_id <= gnt_idx;
            end
        end
    end

    // Responses are also masked while reset is held, because the reset is
    // synchronous and rd_pend may still be set before the first reset edge.
    assign resp_ok    = rd_pend && rst_ni;
    assign m_rvalid_o = resp_ok ? (N_MASTERS'(1) << rd_id) : '0;
    assign m_rdata_o  = resp_ok ? mem_rdata_i : '0;

endmodule
